cpu_sequencer: RTL

Multi-cycle control unit for the 16-bit CPU. It steps each instruction through fetch, decode, register read, ALU execute, memory access and writeback, and asserts the per-stage enables. It owns the program counter and runs the req/ready handshake with the unified memory port. It sits between the ALU, the decoder/register file and the memory interface.

---
 rtl/cpu_sequencer_pkg.sv | 24 ++
 rtl/cpu_sequencer_mem_handshake_timer.sv | 24 ++
 rtl/cpu_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the multi-cycle sequencer: ALU memory-mode codes and
// the 3-bit state encoding that trace/debug logic decodes.
package cpu_sequencer_pkg;

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_REGREAD   = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6,
    S_FAULT     = 3'd7
  } seq_state_t;

  function automatic logic is_mem_access(input logic [1:0] mode);
    return (mode == MEM_READ) || (mode == MEM_WRITE);
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_handshake_timer.sv
// Counts consecutive cycles a memory request waits without mem_ready and
// flags the cycle whose wait would reach the timeout limit.
module mem_handshake_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic expiring
);

  localparam logic [15:0] LAST = 16'(MEM_TIMEOUT - 1);

  logic [15:0] count;

  // Any non-waiting cycle clears, so every new request starts from zero.
  always_ff @(posedge clk) begin
    if (reset || !waiting) count <= '0;
    else                   count <= count + 16'd1;
  end

  assign expiring = (count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the 16-bit CPU: steps each instruction through
// six stages, owns the pc and drives the unified memory port handshake.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic        alu_write_pc,
  input  logic        alu_write_rD,
  input  logic [1:0]  alu_memory_mode,
  input  logic [15:0] alu_out,
  input  logic        halt_req,
  output logic [15:0] pc,
  output logic        en_fetch,
  output logic        en_decode,
  output logic        en_regread,
  output logic        en_alu,
  output logic        en_regwrite,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  seq_state_t state, state_next;
  logic       expiring;

  mem_handshake_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (mem_req & ~mem_ready),
    .expiring(expiring)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (state == S_WRITEBACK) begin
        pc          <= alu_write_pc ? alu_out : pc + 16'd1;
        instr_count <= instr_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    en_fetch     = 1'b0;
    en_decode    = 1'b0;
    en_regread   = 1'b0;
    en_alu       = 1'b0;
    en_regwrite  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        en_fetch = mem_ready;
        if (mem_ready)     state_next = S_DECODE;
        else if (expiring) state_next = S_FAULT;
      end
      S_DECODE: begin
        en_decode  = 1'b1;
        state_next = S_REGREAD;
      end
      S_REGREAD: begin
        en_regread = 1'b1;
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        en_alu     = 1'b1;
        state_next = S_MEMORY;
      end
      S_MEMORY: begin
        if (is_mem_access(alu_memory_mode)) begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (alu_memory_mode == MEM_WRITE);
          if (mem_ready)     state_next = S_WRITEBACK;
          else if (expiring) state_next = S_FAULT;
        end else if (alu_memory_mode == MEM_NOP) begin
          state_next = S_WRITEBACK;
        end else begin
          state_next = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        en_regwrite = alu_write_rD;
        state_next  = halt_req ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (!halt_req) state_next = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_next = S_FAULT;
    endcase
    // Strobes and the memory request stay low for as long as reset is held.
    if (reset) begin
      en_fetch     = 1'b0;
      en_decode    = 1'b0;
      en_regread   = 1'b0;
      en_alu       = 1'b0;
      en_regwrite  = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
    end
  end

endmodule
